// File: rtl/vx_mem_bridge_pkg.sv
// Shared types and helpers for the Vortex memory bridge.
package vx_mem_bridge_pkg;

    localparam int unsigned VX_MEM_DATA_WIDTH = 512;
    localparam int unsigned VX_MEM_ADDR_WIDTH = 26;
    localparam int unsigned VX_MEM_TAG_WIDTH  = 56;

    // One buffered read response, as stored in the response FIFO.
    typedef struct packed {
        logic [VX_MEM_DATA_WIDTH-1:0] data;
        logic [VX_MEM_TAG_WIDTH-1:0]  tag;
    } rsp_entry_t;

    // Width needed to hold a credit count in 0..depth.
    function automatic int unsigned credit_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vx_mem_rsp_fifo.sv
// Generic synchronous FIFO: registered head, no bypass, power-of-two depth.
module vx_mem_rsp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    assign do_pop  = pop & ~empty;
    // A full FIFO may still accept when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    // Next occupancy from the push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset; entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/vx_mem_bridge.sv
// Vortex <-> local RAM bridge: pass-through requests, credit-limited reads,
// buffered fixed-latency responses, sticky out-of-bounds flag and busy status.
module vx_mem_bridge
    import vx_mem_bridge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = VX_MEM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = VX_MEM_ADDR_WIDTH,
    parameter int unsigned TAG_WIDTH    = VX_MEM_TAG_WIDTH,
    parameter int unsigned BYTEEN_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned RSP_DEPTH    = 4,
    parameter int unsigned MEM_WORDS    = 65536
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    mem_req_valid,
    input  logic                    mem_req_rw,
    input  logic [BYTEEN_WIDTH-1:0] mem_req_byteen,
    input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
    input  logic [DATA_WIDTH-1:0]   mem_req_data,
    input  logic [TAG_WIDTH-1:0]    mem_req_tag,
    output logic                    mem_req_ready,

    output logic                    mem_rsp_valid,
    output logic [DATA_WIDTH-1:0]   mem_rsp_data,
    output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
    input  logic                    mem_rsp_ready,

    output logic                    ram_req_valid,
    output logic                    ram_req_rw,
    output logic [BYTEEN_WIDTH-1:0] ram_req_byteen,
    output logic [ADDR_WIDTH-1:0]   ram_req_addr,
    output logic [DATA_WIDTH-1:0]   ram_req_data,
    output logic [TAG_WIDTH-1:0]    ram_req_tag,
    input  logic                    ram_req_ready,

    input  logic                    ram_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   ram_rsp_data,
    input  logic [TAG_WIDTH-1:0]    ram_rsp_tag,

    output logic                    busy,
    output logic                    tb_addr_out_of_bounds
);

    localparam int unsigned CW = credit_width(RSP_DEPTH);
    localparam int unsigned EW = DATA_WIDTH + TAG_WIDTH;
    localparam logic [CW-1:0] CREDITS_MAX = CW'(RSP_DEPTH);
    // One extra bit so MEM_WORDS == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS);

    logic [CW-1:0] credits_q;
    logic [CW-1:0] credits_d;
    logic          can_issue;
    logic          req_fire;
    logic          rd_fire;
    logic          rsp_pop;
    logic          busy_q;
    logic          oob_q;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [EW-1:0] fifo_rdata;

    // Writes never need a credit; reads need a free response slot.
    assign can_issue = mem_req_rw | (credits_q != '0);

    assign ram_req_valid  = mem_req_valid & can_issue;
    assign mem_req_ready  = ram_req_ready & can_issue;
    assign ram_req_rw     = mem_req_rw;
    assign ram_req_byteen = mem_req_byteen;
    assign ram_req_addr   = mem_req_addr;
    assign ram_req_data   = mem_req_data;
    assign ram_req_tag    = mem_req_tag;

    assign req_fire = mem_req_valid & mem_req_ready;
    assign rd_fire  = req_fire & ~mem_req_rw;
    assign rsp_pop  = mem_rsp_valid & mem_rsp_ready;

    assign mem_rsp_valid              = ~fifo_empty;
    assign {mem_rsp_data, mem_rsp_tag} = fifo_rdata;

    assign busy                  = busy_q;
    assign tb_addr_out_of_bounds = oob_q;

    // Credit update: read fire takes one, pop returns one, both cancel.
    always_comb begin
        credits_d = credits_q;
        case ({rd_fire, rsp_pop})
            2'b10:   credits_d = credits_q - CW'(1);
            2'b01:   credits_d = credits_q + CW'(1);
            default: credits_d = credits_q;
        endcase
    end

    // Credits, busy and sticky out-of-bounds state.
    always_ff @(posedge clk) begin
        if (reset) begin
            credits_q <= CREDITS_MAX;
            busy_q    <= 1'b0;
            oob_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            busy_q    <= (credits_q != CREDITS_MAX);
            if (req_fire && ({1'b0, mem_req_addr} >= ADDR_LIMIT)) oob_q <= 1'b1;
        end
    end

    vx_mem_rsp_fifo #(
        .WIDTH (EW),
        .DEPTH (RSP_DEPTH)
    ) rsp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ram_rsp_valid),
        .wdata ({ram_rsp_data, ram_rsp_tag}),
        .pop   (rsp_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // The credit scheme must make a push into a full, non-draining FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(ram_rsp_valid && fifo_full && !rsp_pop));

    a_credit_bound: assert property (@(posedge clk) disable iff (reset)
        ((32'(credits_q) + 32'(fifo_count)) <= RSP_DEPTH));

endmodule
